// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR sequence checker: hunts for the stream, verifies
// LOCK_CNT good predictions, then counts bit errors against a free-running model.
module lfsr_checker #(
    parameter int unsigned nbits    = 8,
    parameter int unsigned LOCK_CNT = 16,
    parameter int unsigned LOSS_CNT = 4,
    parameter int unsigned CNTW     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [nbits-1:0] tap,
    input  logic             in,
    input  logic             clr_count,
    output logic             locked,
    output logic             err,
    output logic [CNTW-1:0]  err_count
);

    localparam int unsigned FILL_W  = $clog2(nbits + 1);
    localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned MISS_W  = $clog2(LOSS_CNT + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state, state_next;
    logic [nbits-1:0]     w, w_next;
    logic [FILL_W-1:0]    fill, fill_next;
    logic [MATCH_W-1:0]   match, match_next;
    logic [MISS_W-1:0]    miss, miss_next;
    logic                 err_next;
    logic [CNTW-1:0]      count_next;
    logic [nbits-1:0]     tap_eff;
    logic                 pred;

    // Bit 0 of the tap mask is always part of the feedback.
    assign tap_eff = tap | nbits'(1);
    assign pred    = ^(w & tap_eff);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= HUNT;
            w         <= '0;
            fill      <= '0;
            match     <= '0;
            miss      <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_next;
            w         <= w_next;
            fill      <= fill_next;
            match     <= match_next;
            miss      <= miss_next;
            locked    <= (state_next == LOCKED);
            err       <= err_next;
            err_count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        w_next     = w;
        fill_next  = fill;
        match_next = match;
        miss_next  = miss;
        err_next   = 1'b0;
        count_next = err_count;

        if (en) begin
            case (state)
                HUNT: begin
                    w_next = {in, w[nbits-1:1]};
                    if (fill == FILL_W'(nbits - 1)) begin
                        state_next = SYNC;
                        fill_next  = '0;
                        match_next = '0;
                    end else begin
                        fill_next = fill + 1'b1;
                    end
                end
                SYNC: begin
                    w_next = {in, w[nbits-1:1]};
                    if ((in == pred) && (|w)) begin
                        if (match == MATCH_W'(LOCK_CNT - 1)) begin
                            state_next = LOCKED;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            match_next = match + 1'b1;
                        end
                    end else begin
                        match_next = '0;
                    end
                end
                LOCKED: begin
                    // Free-running: the model feeds itself so one bad bit is one error.
                    w_next = {pred, w[nbits-1:1]};
                    if (in != pred) begin
                        err_next = 1'b1;
                        if (err_count != {CNTW{1'b1}}) begin
                            count_next = err_count + 1'b1;
                        end
                        if (miss == MISS_W'(LOSS_CNT - 1)) begin
                            state_next = HUNT;
                            fill_next  = '0;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss + 1'b1;
                        end
                    end else begin
                        miss_next = '0;
                    end
                end
                default: state_next = HUNT;
            endcase
        end

        if (clr_count) begin
            count_next = '0;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Randomised bench for lfsr_checker: a bit-history reference model shadows two
// DUT copies (16-bit and 4-bit error counters) and each scenario task checks it.
module tb_lfsr_checker;

    localparam int unsigned NB = 8;
    localparam int M_HUNT = 0, M_SYNC = 1, M_LOCKED = 2;

    logic        clk = 1'b0;
    logic        rst, en, in, clr_count;
    logic [7:0]  tap;
    logic        locked, err, locked4, err4;
    logic [15:0] err_count;
    logic [3:0]  err_count4;

    int    checks = 0, errors = 0, diverge = 0;
    string first_div;

    int    m_mode, m_fill, m_match, m_miss, m_cnt16, m_cnt4;
    bit    m_err;
    bit    m_hist[$];
    logic [7:0] g;

    lfsr_checker #(.nbits(8), .LOCK_CNT(16), .LOSS_CNT(4), .CNTW(16)) dut (
        .clk(clk), .rst(rst), .en(en), .tap(tap), .in(in), .clr_count(clr_count),
        .locked(locked), .err(err), .err_count(err_count)
    );

    lfsr_checker #(.nbits(8), .LOCK_CNT(16), .LOSS_CNT(4), .CNTW(4)) dut4 (
        .clk(clk), .rst(rst), .en(en), .tap(tap), .in(in), .clr_count(clr_count),
        .locked(locked4), .err(err4), .err_count(err_count4)
    );

    always #5 clk = ~clk;

    function automatic bit model_pred();
        bit p = m_hist[0];
        for (int i = 1; i < NB; i++) if (tap[i]) p ^= m_hist[i];
        return p;
    endfunction

    // Reference generator: shifts right, emits q[0], loads feedback at the top.
    function automatic bit gen_next();
        bit o = g[0];
        bit f = g[0];
        for (int i = 1; i < NB; i++) if (tap[i]) f ^= g[i];
        g = {f, g[7:1]};
        return o;
    endfunction

    task automatic model_reset();
        m_mode = M_HUNT; m_fill = 0; m_match = 0; m_miss = 0;
        m_cnt16 = 0; m_cnt4 = 0; m_err = 0;
        m_hist.delete();
        for (int i = 0; i < NB; i++) m_hist.push_back(1'b0);
    endtask

    task automatic push_bit(input bit b);
        void'(m_hist.pop_front());
        m_hist.push_back(b);
    endtask

    // Drive one cycle, advance the model, and tally any disagreement.
    task automatic step(input bit e, input bit b, input bit c);
        bit p, nz;
        @(negedge clk);
        en = e; in = b; clr_count = c;
        m_err = 0;
        if (e) begin
            p = model_pred();
            nz = 0;
            foreach (m_hist[i]) nz |= m_hist[i];
            case (m_mode)
                M_HUNT: begin
                    push_bit(b);
                    m_fill++;
                    if (m_fill == NB) begin m_mode = M_SYNC; m_match = 0; end
                end
                M_SYNC: begin
                    m_match = (b == p && nz) ? m_match + 1 : 0;
                    push_bit(b);
                    if (m_match == 16) begin m_mode = M_LOCKED; m_miss = 0; end
                end
                default: begin
                    if (b != p) begin
                        m_err = 1;
                        if (m_cnt16 < 65535) m_cnt16++;
                        if (m_cnt4 < 15) m_cnt4++;
                        m_miss++;
                    end else begin
                        m_miss = 0;
                    end
                    push_bit(p);
                    if (m_miss == 4) begin m_mode = M_HUNT; m_fill = 0; m_miss = 0; end
                end
            endcase
        end
        if (c) begin m_cnt16 = 0; m_cnt4 = 0; end
        @(posedge clk);
        #1;
        if (locked !== (m_mode == M_LOCKED) || err !== m_err || err_count !== 16'(m_cnt16) ||
            locked4 !== (m_mode == M_LOCKED) || err4 !== m_err || err_count4 !== 4'(m_cnt4)) begin
            if (diverge == 0)
                first_div = $sformatf("t=%0t locked=%b err=%b cnt=%0d cnt4=%0d, model locked=%b err=%b cnt=%0d cnt4=%0d",
                    $time, locked, err, err_count, err_count4, m_mode == M_LOCKED, m_err, m_cnt16, m_cnt4);
            diverge++;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1; en = 0; in = 0; clr_count = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1; en = 0; in = 0; clr_count = 0; tap = 8'hB8;
        model_reset();
        #2;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b want 0", locked); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", err_count); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_clean_lock();
        apply_reset();
        tap = 8'hB8; g = 8'h01;
        for (int k = 1; k <= 2000; k++) begin
            step(1, gen_next(), 0);
            if (k == 23) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0 after bit 23", locked); end
            end
            if (k == 24) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_at_24: got %b want 1", locked); end
            end
        end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_count: got %0d want 0", err_count); end
        checks++; if (diverge !== 0) begin errors++; $display("FAIL clean_model: %0d cycles differ, first %s", diverge, first_div); end
        diverge = 0;
    endtask

    task automatic test_single_flip();
        int pulses = 0;
        bit dropped = 0;
        bit b;
        for (int k = 1; k <= 200; k++) begin
            b = gen_next();
            step(1, (k == 100) ? ~b : b, 0);
            if (err === 1'b1) pulses++;
            if (locked !== 1'b1) dropped = 1;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL flip_pulses: got %0d want 1", pulses); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL flip_count: got %0d want 1", err_count); end
        checks++; if (dropped !== 1'b0) begin errors++; $display("FAIL flip_locked: lock dropped, want held"); end
        checks++; if (diverge !== 0) begin errors++; $display("FAIL flip_model: %0d cycles differ, first %s", diverge, first_div); end
        diverge = 0;
    endtask

    task automatic test_loss();
        int pulses = 0;
        step(0, 0, 1);
        for (int k = 1; k <= 4; k++) begin
            step(1, ~gen_next(), 0);
            if (err === 1'b1) pulses++;
            if (k == 3) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL loss_early: got %b want 1 after 3 bad bits", locked); end
            end
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL loss_drop: got %b want 0", locked); end
        checks++; if (pulses !== 4) begin errors++; $display("FAIL loss_pulses: got %0d want 4", pulses); end
        checks++; if (err_count !== 16'd4) begin errors++; $display("FAIL loss_count: got %0d want 4", err_count); end
        for (int k = 1; k <= 24; k++) begin
            step(1, gen_next(), 0);
            if (k == 23) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL relock_early: got %b want 0", locked); end
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL relock_24: got %b want 1", locked); end
        checks++; if (diverge !== 0) begin errors++; $display("FAIL loss_model: %0d cycles differ, first %s", diverge, first_div); end
        diverge = 0;
    endtask

    task automatic test_saturate();
        step(0, 0, 1);
        for (int k = 0; k < 20; k++) begin
            step(1, ~gen_next(), 0);
            step(1, gen_next(), 0);
        end
        checks++; if (err_count4 !== 4'd15) begin errors++; $display("FAIL sat_count4: got %0d want 15", err_count4); end
        checks++; if (err_count !== 16'd20) begin errors++; $display("FAIL sat_count16: got %0d want 20", err_count); end
        step(1, ~gen_next(), 1);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL clr_err: got %b want 1", err); end
        checks++; if (err_count !== 16'd0 || err_count4 !== 4'd0) begin
            errors++; $display("FAIL clr_priority: got %0d/%0d want 0/0", err_count, err_count4);
        end
        checks++; if (diverge !== 0) begin errors++; $display("FAIL sat_model: %0d cycles differ, first %s", diverge, first_div); end
        diverge = 0;
    endtask

    task automatic test_zeros();
        bit seen = 0;
        apply_reset();
        for (int k = 0; k < 500; k++) begin
            step(1, 0, 0);
            if (locked === 1'b1) seen = 1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL zeros_lock: locked seen, want never"); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL zeros_count: got %0d want 0", err_count); end
    endtask

    task automatic test_random();
        int burst = 0;
        bit seen = 0;
        bit e, b, c;
        apply_reset();
        tap = 8'($urandom_range(1, 255));
        g = 8'($urandom_range(1, 255));
        for (int k = 0; k < 3000; k++) begin
            if (k == 1500) tap = 8'hB8;
            e = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) == 0);
            b = 0;
            if (e) begin
                b = gen_next();
                if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(4, 6);
                if (burst > 0) begin b = ~b; burst--; end
                else if ($urandom_range(0, 49) == 0) b = ~b;
            end
            step(e, b, c);
            if (locked === 1'b1) seen = 1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rand_lock: never locked, want lock"); end
        checks++; if (diverge !== 0) begin errors++; $display("FAIL rand_model: %0d cycles differ, first %s", diverge, first_div); end
        diverge = 0;
    endtask

    task automatic test_async_reset();
        int ebits = 0;
        bit e;
        apply_reset();
        tap = 8'hB8; g = 8'($urandom_range(1, 255));
        for (int k = 0; k < 300 && m_mode != M_LOCKED; k++) begin
            e = ($urandom_range(0, 2) != 0);
            step(e, e ? gen_next() : 1'b0, 0);
        end
        step(1, ~gen_next(), 0);
        checks++; if (err !== 1'b1 || locked !== 1'b1) begin
            errors++; $display("FAIL pre_reset: err=%b locked=%b want 1/1", err, locked);
        end
        #1 rst = 1;
        #1;
        checks++; if (locked !== 1'b0 || err !== 1'b0 || err_count !== 16'd0 || err_count4 !== 4'd0) begin
            errors++; $display("FAIL async_reset: locked=%b err=%b cnt=%0d want 0/0/0", locked, err, err_count);
        end
        model_reset();
        #1 rst = 0;
        for (int k = 0; k < 300 && locked !== 1'b1; k++) begin
            e = ($urandom_range(0, 2) != 0);
            if (e) ebits++;
            step(e, e ? gen_next() : 1'b0, 0);
        end
        checks++; if (ebits !== 24) begin errors++; $display("FAIL relock_bits: got %0d en bits want 24", ebits); end
        checks++; if (diverge !== 0) begin errors++; $display("FAIL async_model: %0d cycles differ, first %s", diverge, first_div); end
        diverge = 0;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_flip();
        test_loss();
        test_saturate();
        test_zeros();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
LFSR_CHECKER -- requirements
Module: lfsr_checker

Interface
REQ-001 The module SHALL have a parameter nbits, default 8: LFSR length in bits.
REQ-002 The module SHALL have a parameter LOCK_CNT, default 16: consecutive good predictions needed to declare lock.
REQ-003 The module SHALL have a parameter LOSS_CNT, default 4: consecutive mispredictions while locked that cause loss of lock.
REQ-004 The module SHALL have a parameter CNTW, default 16: error counter width.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-high.
REQ-007 Port en, input, 1: in carries a valid stream bit this cycle.
REQ-008 Port tap, input, nbits: feedback tap mask; bit 0 ignored (always included); held stable during operation.
REQ-009 Port in, input, 1: received serial bit from the LFSR generator output.
REQ-010 Port clr_count, input, 1: synchronous clear of err_count.
REQ-011 Port locked, output, 1: registered; high in LOCKED state.
REQ-012 Port err, output, 1: registered one-cycle pulse per counted misprediction.
REQ-013 Port err_count, output, CNTW: registered saturating error count.

Function
REQ-014 The module SHALL keep an nbits window w: w[0] oldest received bit, w[nbits-1] newest.
REQ-015 The predicted bit SHALL be p = w[0] XOR (XOR of w[i] for i=1..nbits-1 where tap[i]=1), matching a generator whose register shifts right, outputs q[0] and loads its feedback into q[nbits-1].
REQ-016 On each en cycle, the window SHALL shift: w <= {new_bit, w[nbits-1:1]}.
REQ-017 With en=0, all state SHALL hold and err SHALL be 0 on the next cycle.
REQ-018 FSM states SHALL be HUNT, SYNC and LOCKED.
REQ-019 HUNT: new_bit=in; a fill counter SHALL increment per en bit, and on the nbits-th bit the FSM SHALL go to SYNC with match count 0.
REQ-020 SYNC: new_bit=in (self-synchronising), and no err SHALL be flagged.
REQ-021 SYNC: in==p with w nonzero SHALL increment the match count; mismatch or w all-zero SHALL reset it to 0.
REQ-022 SYNC: the en bit that brings the match count to LOCK_CNT SHALL move the FSM to LOCKED.
REQ-023 LOCKED: new_bit=p (free-running model), so one corrupted input bit produces exactly one error.
REQ-024 LOCKED: in!=p SHALL set err=1 next cycle, increment err_count (saturating at 2^CNTW-1) and increment the miss count; in==p SHALL reset the miss count to 0.
REQ-025 LOCKED: the en bit that brings the miss count to LOSS_CNT SHALL be counted as an error, then the FSM SHALL go to HUNT with fill and miss counts 0.
REQ-026 locked SHALL equal (state==LOCKED) and update on the same edge as the state change.
REQ-027 clr_count=1 SHALL set err_count=0 next cycle, taking priority over a simultaneous increment; err and the FSM SHALL be unaffected.
REQ-028 A tap change SHALL take effect on the next en bit; no automatic re-hunt.

Reset
REQ-029 rst=1 SHALL immediately force state=HUNT, w=0, all internal counters 0, locked=0, err=0 and err_count=0, regardless of clk or en, including mid-lock.
REQ-030 After rst falls, operation SHALL resume on the first en cycle; no extra latency cycles.

Verification
REQ-031 Clean lock: nbits=8, tap=8'hB8, generator seed 8'h01, en=1 continuously -> locked rises one cycle after the 24th bit; err_count stays 0 over 2000 bits.
REQ-032 Single flip: after lock, invert bit 100 only -> exactly one err pulse, err_count=1, locked stays 1.
REQ-033 Loss: after lock, drive ~p for 4 bits -> err pulses on 4 cycles, err_count=4, locked falls one cycle after the 4th bad bit, and the FSM relocks 24 bits after the clean stream resumes.
REQ-034 All-zero input from reset for 500 bits -> locked never asserts, err_count=0.
REQ-035 Counter edges: with CNTW=4 and 20 forced errors, err_count saturates at 15; clr_count on an error cycle gives err_count=0 with err=1.
REQ-036 Async reset while locked with en gaps -> all outputs 0 without a clock edge, and relock takes 24 en bits.
